// File: rtl/pattern_dp_sched.sv
// pattern_dp_sched: time-multiplexes one registered pattern datapath between
// NUM_REQ requesters. A round-robin arbiter grants one request and drives its
// vector onto dp_in. The block then waits SETTLE cycles, captures dp_out, and
// returns it on a valid/ready response tagged with the requester id.
//
// Ports:
//   blif_clk_net    clock; all state updates on the rising edge
//   blif_reset_net  synchronous active-high reset
//   req_valid/req_vec/req_ready   per-requester request, one-hot grant
//   dp_in / dp_out  datapath drive vector and datapath result
//   rsp_valid/rsp_ready/rsp_id/rsp_data   response port
//   busy            high whenever the scheduler is not idle
// Optional build macro PATTERN_DP_SIG_EN adds sig_clr (in) and sig (out), a
// 16-bit MISR over every accepted response.
module pattern_dp_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IN_W    = 11,
  parameter int unsigned OUT_W   = 9,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    blif_clk_net,
  input  logic                    blif_reset_net,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         dp_in,
  input  logic [OUT_W-1:0]        dp_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    busy
`ifdef PATTERN_DP_SIG_EN
  ,
  input  logic                    sig_clr,
  output logic [15:0]             sig
`endif
);

  localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [IN_W-1:0]     dp_in_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [OUT_W-1:0]    rsp_data_q;
  logic                busy_q;

  logic [NUM_REQ-1:0]  grant_c;
  logic [ID_W-1:0]     grant_idx_c;
  logic [IN_W-1:0]     sel_vec_c;
  logic                found_c;
  logic                rsp_hs_c;

  // Round-robin search: first valid at or above rr_ptr, then wrap to below it.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    sel_vec_c   = '0;
    found_c     = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found_c && (i >= int'(rr_ptr_q)) &&
          ((req_valid & (NUM_REQ'(1) << i)) != '0)) begin
        found_c     = 1'b1;
        grant_c     = NUM_REQ'(1) << i;
        grant_idx_c = ID_W'(i);
        sel_vec_c   = IN_W'(req_vec >> (i * int'(IN_W)));
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found_c && (i < int'(rr_ptr_q)) &&
          ((req_valid & (NUM_REQ'(1) << i)) != '0)) begin
        found_c     = 1'b1;
        grant_c     = NUM_REQ'(1) << i;
        grant_idx_c = ID_W'(i);
        sel_vec_c   = IN_W'(req_vec >> (i * int'(IN_W)));
      end
    end
    // Grants are only offered while idle.
    if (state_q != ST_IDLE) begin
      grant_c = '0;
      found_c = 1'b0;
    end
  end

  assign rr_ptr_d = (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
  assign rsp_hs_c = (state_q == ST_RESP) && rsp_ready;

  // Scheduler FSM with registered datapath drive and response outputs.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      dp_in_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            dp_in_q  <= sel_vec_c;
            rsp_id_q <= grant_idx_c;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CNT_W'(SETTLE);
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Last settle cycle: dp_out now reflects dp_in.
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q  <= dp_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_hs_c) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = grant_c;
  assign dp_in     = dp_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

`ifdef PATTERN_DP_SIG_EN
  logic [15:0] sig_q;
  logic        sig_fb_c;

  // Feedback taps for x^16 + x^12 + x^5 + 1.
  assign sig_fb_c = sig_q[15] ^ sig_q[11] ^ sig_q[4];

  // Response signature; clear takes priority over an accepted response.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net || sig_clr) begin
      sig_q <= 16'hFFFF;
    end else if (rsp_hs_c) begin
      sig_q <= {sig_q[14:0], sig_fb_c} ^ 16'(rsp_data_q);
    end
  end

  assign sig = sig_q;
`endif

endmodule

// File: doc/pattern_dp_sched.md
Name: pattern_dp_sched

Overview:
- Time-multiplexes one merged pattern datapath (11 primary inputs, 9 outputs, two register stages) between several requesters.
- Round-robin arbiter picks one requester's input vector and drives it onto the datapath.
- Waits a fixed settle time for the registered pattern logic, captures the outputs and returns them through a valid/ready response port tagged with the requester id.
- Sits between the pattern-merge netlist and the test/stimulus clients.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 11, width of the datapath input vector.
- OUT_W, 9, width of the datapath output vector.
- SETTLE, 2, clock cycles between the dp_in update and a valid dp_out (must be >= 1).
- ID_W, 2, requester id width; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- blif_clk_net  input  1  single clock; all state updates on the rising edge.
- blif_reset_net  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_vec  input  NUM_REQ*IN_W  per-requester vector; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] and req_ready[i] are both high.
- dp_in  output  IN_W  registered vector driven to the datapath.
- dp_out  input  OUT_W  datapath outputs.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  OUT_W  captured dp_out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE, req_ready 0, dp_in 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, rr_ptr 0, wait counter 0.
- Reset is synchronous; asserting it mid-transaction discards that transaction (no response is produced) and restores all reset values on the next edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i], searching rr_ptr, rr_ptr+1 … modulo NUM_REQ.
  - req_ready is 0 if no request is valid.
  - On the handshake edge: dp_in <= slice i, rsp_id <= i, rr_ptr <= (i+1) mod NUM_REQ, counter <= SETTLE, go to WAIT.
- WAIT:
  - req_ready is all 0; dp_in is held stable.
  - The counter decrements each cycle.
  - In the cycle the counter reads 1: rsp_data <= dp_out, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready.
  - On rsp_valid and rsp_ready: rsp_valid <= 0, go to IDLE.
  - A new grant is made in the cycle after entering IDLE.
- Latency: handshake at cycle T, so dp_in changes at T+1 and rsp_valid rises at T+1+SETTLE (T+3 for the default).
- Minimum transaction period: SETTLE+2 cycles with rsp_ready tied high.
- dp_in retains the last granted vector while IDLE; it is not cleared between transactions.
- Fairness: if every requester holds valid, grants go i, i+1, … and no requester waits more than NUM_REQ-1 transactions.
- Requests arriving while busy are not acknowledged. A requester must keep req_valid and req_vec stable until granted.
- A requester that drops req_valid before its grant is skipped with no side effects.
- rsp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: PATTERN_DP_SIG_EN.
- When defined, add:
  - Output sig (16 bits): MISR with polynomial x^16+x^12+x^5+1, reset 16'hFFFF.
  - Input sig_clr (1 bit).
- Update rule: on every response handshake, sig <= {sig[14:0], fb} XOR zero-extended rsp_data, where fb is the polynomial feedback bit.
- sig_clr (synchronous) sets sig back to 16'hFFFF. If sig_clr coincides with a handshake, sig_clr wins.
- When not defined: no sig or sig_clr ports and no MISR logic.

Test Plan:
- Reset then single request: req_valid=4'b0001, vec0=11'h5A5 -> req_ready=4'b0001 at T, dp_in=11'h5A5 at T+1, rsp_valid at T+3, rsp_id=0, rsp_data equals the model's dp_out.
- Round robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one grant every 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data and rsp_id stable; busy=1; no req_ready asserted; the next grant comes 1 cycle after rsp_ready=1.
- Reset in WAIT: assert blif_reset_net at T+2 -> next cycle rsp_valid=0, dp_in=0, busy=0; no response emitted; rr_ptr=0 so requester 0 wins the next grant.
- Pointer wrap: grant requester 3, then only req_valid[1] and req_valid[3] asserted -> requester 1 granted first.
- With PATTERN_DP_SIG_EN: two responses 9'h001 and 9'h100 after sig_clr -> sig matches the reference MISR model; sig_clr then returns sig to 16'hFFFF.
